// File: rtl/qr_pkg.sv
// Shared constants, state encoding and column packing helpers for the QR detector stages.
package qr_pkg;
  localparam int DATA_W = 28;
  localparam int NORM_W = 56;
  localparam int SCALE  = 10000;
  localparam int Q_FRAC = 14;
  localparam int DVD_W  = 56;
  localparam int NCOMP  = 8;

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  // Slot k holds bits [k*DATA_W +: DATA_W]; real_n at slot 2(n-1), imag_n at 2(n-1)+1.
  typedef logic [NCOMP-1:0][DATA_W-1:0] col_t;

  function automatic int re_slot(input int n);
    return 2 * (n - 1);
  endfunction

  function automatic int im_slot(input int n);
    return 2 * (n - 1) + 1;
  endfunction
endpackage

// File: rtl/serial_udiv.sv
// Unsigned radix-2 restoring divider, one quotient bit per cycle, MSB first.
// start_i performs the first iteration; done_o/quotient_o are valid during the final one.
module serial_udiv #(
  parameter int DVD_W = 56,
  parameter int DSR_W = 56
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [DVD_W:0]   dividend_i,
  input  logic [DSR_W-1:0] divisor_i,
  output logic             done_o,
  output logic [DVD_W-1:0] quotient_o
);
  localparam int CNT_W = $clog2(DVD_W + 1);

  logic [DSR_W:0]   rem_q, rem_d, rem_src;
  logic [DSR_W+1:0] rem_sh;
  logic [DVD_W-1:0] quo_q, quo_d, quo_src;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, ge;

  // The dividend's extra MSB seeds the remainder so the widened dividend costs no cycle.
  always_comb begin
    rem_src = start_i ? {{DSR_W{1'b0}}, dividend_i[DVD_W]} : rem_q;
    quo_src = start_i ? dividend_i[DVD_W-1:0] : quo_q;
    rem_sh  = {rem_src, quo_src[DVD_W-1]};
    ge      = rem_sh >= {2'b00, divisor_i};
    rem_d   = ge ? (DSR_W+1)'(rem_sh - {2'b00, divisor_i}) : rem_sh[DSR_W:0];
    quo_d   = {quo_src[DVD_W-2:0], ge};
  end

  assign done_o     = busy_q && (cnt_q == CNT_W'(DVD_W - 1));
  assign quotient_o = quo_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      cnt_q  <= CNT_W'(1);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_q + CNT_W'(1);
      if (done_o) busy_q <= 1'b0;
    end
  end
endmodule

// File: rtl/qcol_normalize.sv
// Serial column normalisation q = a/||a|| over 8 components with one shared divider.
// Define QCOL_NORMALIZE_ROUND_EN for round-half-away-from-zero instead of truncation.
module qcol_normalize
  import qr_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*DATA_W-1:0] col_in,
  input  logic [NORM_W-1:0]   norm_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*DATA_W-1:0] q_out,
  output logic                div_zero,
  output logic                busy
);
  localparam logic [DVD_W-1:0] POS_LIM = DVD_W'((64'd1 << (DATA_W - 1)) - 64'd1);
  localparam logic [DVD_W-1:0] NEG_LIM = DVD_W'(64'd1 << (DATA_W - 1));

  state_t            state_q, state_d;
  col_t              col_q, col_d, q_q, q_d;
  logic [NORM_W-1:0] norm_q, norm_d;
  logic [2:0]        idx_q, idx_d;
  logic              dz_q, dz_d, start_q, start_d;

  logic [DATA_W-1:0] a, sat;
  logic [DATA_W:0]   mag;
  logic [DVD_W-1:0]  base, quo;
  logic [DVD_W:0]    dvd;
  logic              neg, div_done;

  // Magnitude path: -2^27 gets a DATA_W+1 bit magnitude, so no special case.
  always_comb begin
    a    = col_q[idx_q];
    neg  = a[DATA_W-1];
    mag  = neg ? (~{1'b1, a} + (DATA_W+1)'(1)) : {1'b0, a};
    base = (DVD_W'(mag) * DVD_W'(SCALE)) << Q_FRAC;
`ifdef QCOL_NORMALIZE_ROUND_EN
    dvd  = {1'b0, base} + {1'b0, norm_q >> 1};
`else
    dvd  = {1'b0, base};
`endif
    if (neg) sat = (quo >= NEG_LIM) ? {1'b1, {(DATA_W-1){1'b0}}} : (~quo[DATA_W-1:0] + DATA_W'(1));
    else     sat = (quo >  POS_LIM) ? {1'b0, {(DATA_W-1){1'b1}}} : quo[DATA_W-1:0];
  end

  serial_udiv #(.DVD_W(DVD_W), .DSR_W(NORM_W)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start_q),
    .dividend_i(dvd),
    .divisor_i (norm_q),
    .done_o    (div_done),
    .quotient_o(quo)
  );

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    norm_d  = norm_q;
    q_d     = q_q;
    idx_d   = idx_q;
    dz_d    = dz_q;
    start_d = 1'b0;
    unique case (state_q)
      IDLE: if (in_valid) begin
        col_d  = col_in;
        norm_d = norm_in;
        q_d    = '0;
        idx_d  = '0;
        if (norm_in == '0) begin
          dz_d    = 1'b1;
          state_d = DONE;
        end else begin
          dz_d    = 1'b0;
          start_d = 1'b1;
          state_d = DIV;
        end
      end
      DIV: if (div_done) begin
        q_d[idx_q] = sat;
        idx_d      = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = DONE;
        else               start_d = 1'b1;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      norm_q  <= '0;
      q_q     <= '0;
      idx_q   <= '0;
      dz_q    <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      norm_q  <= norm_d;
      q_q     <= q_d;
      idx_q   <= idx_d;
      dz_q    <= dz_d;
      start_q <= start_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign q_out     = q_q;
  assign div_zero  = dz_q;
endmodule

// File: tb/tb_qcol_normalize.sv
// Directed-vector bench for qcol_normalize with hand-computed expected quotients.
module tb_qcol_normalize;
  import qr_pkg::*;

  logic                clk, rst_n, in_valid, in_ready, out_valid, out_ready, div_zero, busy;
  logic [8*DATA_W-1:0] col_in, q_out;
  logic [NORM_W-1:0]   norm_in;
  int total = 0;
  int bad   = 0;

  qcol_normalize dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .col_in(col_in), .norm_in(norm_in), .out_valid(out_valid), .out_ready(out_ready),
    .q_out(q_out), .div_zero(div_zero), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic signed [DATA_W-1:0] qc(input int k);
    return q_out[k*DATA_W +: DATA_W];
  endfunction

  // Handshake at cycle 0; returns the cycle in which out_valid is first seen.
  task automatic run(input col_t c, input logic [NORM_W-1:0] n, input bit noise, output int lat);
    @(negedge clk);
    col_in = c; norm_in = n; in_valid = 1'b1;
    @(posedge clk); #1;
    if (noise) begin
      col_in = ~c; norm_in = '0;
    end else in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 1000) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 100) in_valid = 1'b0;
    end
  endtask

  task automatic take(input string tag);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk({tag, "_ov_drop"}, out_valid, 0);
    chk({tag, "_rdy_back"}, in_ready, 1);
  endtask

  initial begin
    col_t c;
    int   lat;
    bit   stable;
    logic [8*DATA_W-1:0] snap;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; col_in = '0; norm_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_div_zero", div_zero, 0);
    chk("rst_q_nonzero", q_out != '0, 0);
    @(negedge clk); rst_n = 1'b1;

    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk("idle_ordy_ov", out_valid, 0);
    chk("idle_ordy_rdy", in_ready, 1);

    c = '0; c[re_slot(1)] = DATA_W'(3); c[im_slot(1)] = DATA_W'(4);
    run(c, 56'd50000, 1'b0, lat);
    chk("pos_latency", lat, 449);
    chk("pos_re1", qc(0), 9830);
    chk("pos_im1", qc(1), 13107);
    chk("pos_rest_nonzero", q_out[8*DATA_W-1:2*DATA_W] != '0, 0);
    chk("pos_dz", div_zero, 0);
    chk("pos_busy", busy, 1);
    chk("pos_in_ready", in_ready, 0);
    take("pos");

    c = '0; c[re_slot(1)] = -DATA_W'(3); c[im_slot(1)] = -DATA_W'(4);
    run(c, 56'd50000, 1'b1, lat);
    chk("neg_latency", lat, 449);
    chk("neg_re1", qc(0), -9830);
    chk("neg_im1", qc(1), -13107);
    chk("neg_dz", div_zero, 0);
    take("neg");

    c = '0; c[re_slot(1)] = DATA_W'(1);
    run(c, 56'd7000, 1'b0, lat);
`ifdef QCOL_NORMALIZE_ROUND_EN
    chk("frac_re1", qc(0), 23406);
`else
    chk("frac_re1", qc(0), 23405);
`endif
    take("frac");

    c = '0; c[re_slot(1)] = DATA_W'(5); c[re_slot(3)] = -DATA_W'(7);
    run(c, 56'd0, 1'b0, lat);
    chk("zero_latency", lat, 1);
    chk("zero_q_nonzero", q_out != '0, 0);
    chk("zero_dz", div_zero, 1);
    take("zero");

    c = '0; c[re_slot(1)] = DATA_W'(100000); c[im_slot(1)] = -DATA_W'(100000);
    c[re_slot(3)] = {1'b1, {(DATA_W-1){1'b0}}};
    run(c, 56'd1, 1'b0, lat);
    chk("sat_pos", qc(0), 134217727);
    chk("sat_neg", qc(1), -134217728);
    chk("sat_most_neg", qc(4), -134217728);
    chk("sat_zero_comp", qc(7), 0);
    chk("sat_dz", div_zero, 0);

    snap = q_out; stable = 1'b1;
    @(negedge clk); in_valid = 1'b1; col_in = '1; norm_in = '0;
    repeat (20) begin
      @(posedge clk); #1;
      if (q_out !== snap || !out_valid || in_ready) stable = 1'b0;
    end
    chk("hold_stable", stable, 1);
    chk("hold_dz", div_zero, 0);
    @(negedge clk); in_valid = 1'b0;
    take("hold");

    c = '0; c[re_slot(1)] = DATA_W'(3); c[im_slot(1)] = DATA_W'(4);
    @(negedge clk); col_in = c; norm_in = 56'd50000; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    repeat (100) @(negedge clk);
    rst_n = 1'b0; #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_q_nonzero", q_out != '0, 0);
    @(negedge clk); rst_n = 1'b1;

    c = '0; c[im_slot(4)] = -DATA_W'(1);
    run(c, 56'd7000, 1'b0, lat);
    chk("post_rst_latency", lat, 449);
`ifdef QCOL_NORMALIZE_ROUND_EN
    chk("post_rst_im4", qc(7), -23406);
`else
    chk("post_rst_im4", qc(7), -23405);
`endif
    take("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
